// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-stated single-port data memory responder for the memory stage
// Optional feature macro: DM_RESPONDER_BOUNDS_CHECK_EN (fault out-of-range word indices)
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wea,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;

    logic [3:0]    cnt_q;
    logic [29:0]   idx_q;
    logic [3:0]    wea_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic [29:0]   c_idx;
    logic [3:0]    c_wea;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_row;
    logic [31:0]   merged;
    logic          c_fault;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    assign accept = req && (state_q == IDLE);
    // Zero-wait accesses commit on the accepting edge, so they must use the live request fields
    assign commit  = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
    assign c_idx   = (WAIT_CYCLES == 0) ? addr[31:2] : idx_q;
    assign c_wea   = (WAIT_CYCLES == 0) ? wea : wea_q;
    assign c_wdata = (WAIT_CYCLES == 0) ? wdata : wdata_q;
    assign c_row   = c_idx[AW-1:0];

`ifdef DM_RESPONDER_BOUNDS_CHECK_EN
    assign c_fault = ({2'b00, c_idx} >= 32'(DEPTH_WORDS));
`else
    logic unused_idx_hi;
    assign unused_idx_hi = ^c_idx;
    assign c_fault = 1'b0;
`endif

    always_comb begin
        merged = mem[c_row];
        for (int i = 0; i < 4; i++) begin
            if (c_wea[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign rvalid = (state_q == RESP);
    assign err    = rvalid && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 30'd0;
            wea_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= addr[31:2];
                wea_q   <= wea;
                wdata_q <= wdata;
                cnt_q   <= CNT_INIT;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                rdata <= c_fault ? 32'd0 : merged;
                err_q <= c_fault;
            end
        end
    end

    // Array is deliberately outside the reset domain; a reset at the commit edge still blocks the write
    always_ff @(posedge clk) begin
        if (!rst && commit && !c_fault) mem[c_row] <= merged;
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req, ready, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wea;
    logic        req0, ready0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  wea0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [1024];

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wea(wea), .wdata(wdata),
        .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .addr(addr0), .wea(wea0), .wdata(wdata0),
        .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rdata, mon_e.d);
                check("err", {31'd0, err}, {31'd0, mon_e.e});
                check("latency", cyc, mon_e.c);
            end
        end else if (!rst) begin
            check("err_idle", {31'd0, err}, 32'd0);
        end
    end

    task automatic expect_access(input logic [31:0] a, input logic [3:0] we,
                                 input logic [31:0] wd, input int resp_cyc);
        exp_t        e;
        logic [29:0] ix;
        logic [31:0] w;
        ix = a[31:2];
`ifdef DM_RESPONDER_BOUNDS_CHECK_EN
        if (ix >= 30'd1024) begin
            e.d = 32'd0;
            e.e = 1'b1;
        end else
`endif
        begin
            w = model[ix[9:0]];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
            end
            model[ix[9:0]] = w;
            e.d = w;
            e.e = 1'b0;
        end
        e.c = resp_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        wait_ready();
        req = 1'b1; addr = a; wea = we; wdata = wd;
        expect_access(a, we, wd, cyc + 2);
        @(negedge clk);
        req = 1'b0; addr = $urandom; wea = 4'($urandom); wdata = $urandom;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req = 1'b0; addr = '0; wea = '0; wdata = '0;
        req0 = 1'b0; addr0 = '0; wea0 = '0; wdata0 = '0;
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd1);
        rst = 1'b0;

        // word store/load and byte-lane merge
        access(32'h10, 4'hF, 32'hDEADBEEF);
        access(32'h10, 4'h0, 32'h0);
        access(32'h20, 4'hF, 32'h11223344);
        access(32'h20, 4'b0100, 32'h00AA0000);
        access(32'h20, 4'h0, 32'h0);

        // req held high: one access every three cycles
        wait_ready();
        req = 1'b1; addr = 32'h10; wea = 4'h0; wdata = 32'h0;
        for (int j = 0; j < 9; j++) begin
            if (j % 3 == 0) expect_access(32'h10, 4'h0, 32'h0, cyc + 2);
            check("busy_ready", {31'd0, ready}, (j % 3 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        req = 1'b0;

        // reset during WAIT aborts the write
        access(32'h40, 4'hF, 32'h0);
        wait_ready();
        req = 1'b1; addr = 32'h40; wea = 4'hF; wdata = 32'h55555555;
        @(negedge clk);
        req = 1'b0;
        check("abort_in_wait", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_rvalid", {31'd0, rvalid}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        access(32'h40, 4'h0, 32'h0);

        // index 1024: fault with bounds check, wrap to word 0 without
        access(32'h0, 4'hF, 32'hCAFEF00D);
        access(32'h1000, 4'hF, 32'h12345678);
        access(32'h0, 4'h0, 32'h0);
        access(32'h1000, 4'h0, 32'h0);

        for (int i = 0; i < 16; i++) access(32'h100 + 32'(4 * i), 4'hF, $urandom);
        for (int i = 0; i < 24; i++)
            access(32'h100 + 32'(4 * $urandom_range(0, 15)), 4'($urandom), $urandom);

        // zero-wait instance
        @(negedge clk);
        check("w0_ready", {31'd0, ready0}, 32'd1);
        req0 = 1'b1; addr0 = 32'h8; wea0 = 4'hF; wdata0 = 32'hA5A5A5A5;
        @(negedge clk);
        req0 = 1'b0; wea0 = 4'h0; wdata0 = 32'h0;
        check("w0_rvalid", {31'd0, rvalid0}, 32'd1);
        check("w0_busy", {31'd0, ready0}, 32'd0);
        check("w0_rdata", rdata0, 32'hA5A5A5A5);
        check("w0_err", {31'd0, err0}, 32'd0);
        @(negedge clk);
        check("w0_rvalid_off", {31'd0, rvalid0}, 32'd0);
        check("w0_ready_back", {31'd0, ready0}, 32'd1);
        check("w0_rdata_hold", rdata0, 32'hA5A5A5A5);
        req0 = 1'b1; addr0 = 32'h8; wea0 = 4'b0001; wdata0 = 32'h0000003C;
        @(negedge clk);
        req0 = 1'b0;
        check("w0_merge_rvalid", {31'd0, rvalid0}, 32'd1);
        check("w0_merge_rdata", rdata0, 32'hA5A5A53C);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
